// File: rtl/axil_pkg.sv
// Shared AXI4-Lite request/response bundles, response codes and arbiter state type
// for the core-to-memory interconnect.
package axil_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic              ar_valid;
        logic [ADDR_W-1:0] araddr;
        logic              aw_valid;
        logic [ADDR_W-1:0] awaddr;
        logic              w_valid;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
        logic              r_ready;
        logic              b_ready;
    } axil_req_t;

    typedef struct packed {
        logic              ar_ready;
        logic              aw_ready;
        logic              w_ready;
        logic              r_valid;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        rresp;
        logic              b_valid;
        logic [1:0]        bresp;
    } axil_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR      = 2'd2,
        ST_WR_RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arbiter_chk.sv
// Protocol checker for the arbiter: the instruction-fetch master is read-only and must
// never raise a write-address or write-data valid.
module mem_arbiter_chk
    import axil_pkg::*;
(
    input logic      clk,
    input logic      rst,
    input axil_req_t ifu_req
);

    // IFU write channels are tied off by construction; any activity is a master bug.
    ifu_no_write_a : assert property (@(posedge clk) disable iff (rst)
        !ifu_req.aw_valid && !ifu_req.w_valid);

endmodule

// File: rtl/mem_arbiter.sv
// 2:1 AXI4-Lite arbiter between instruction fetch (read-only) and load/store masters onto
// one memory port; a single transaction in flight, channels wired through once granted.
module mem_arbiter
    import axil_pkg::*;
#(
    parameter bit LSU_PRIORITY = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  axil_req_t ifu_req,
    output axil_rsp_t ifu_rsp,
    input  axil_req_t lsu_req,
    output axil_rsp_t lsu_rsp,
    output axil_req_t mem_req,
    input  axil_rsp_t mem_rsp
);

    arb_state_t state_q;
    owner_t     owner_q;
    logic       aw_done_q;
    logic       w_done_q;
    logic       aw_done_d;
    logic       w_done_d;
    logic       lsu_wr_s;
    logic       lsu_win_s;
    logic       r_hs_s;
    logic       b_hs_s;
    axil_req_t  sel_req_s;
    axil_rsp_t  own_rsp_s;
    logic       unused_ifu_s;

    assign unused_ifu_s = ^{ifu_req.aw_valid, ifu_req.awaddr, ifu_req.w_valid,
                            ifu_req.wdata, ifu_req.wstrb, ifu_req.b_ready};

    assign lsu_wr_s  = lsu_req.aw_valid | lsu_req.w_valid;
    assign lsu_win_s = (lsu_wr_s | lsu_req.ar_valid) & (LSU_PRIORITY | ~ifu_req.ar_valid);
    assign r_hs_s    = mem_rsp.r_valid & mem_req.r_ready;
    assign b_hs_s    = mem_rsp.b_valid & mem_req.b_ready;
    assign aw_done_d = aw_done_q | (mem_req.aw_valid & mem_rsp.aw_ready);
    assign w_done_d  = w_done_q  | (mem_req.w_valid  & mem_rsp.w_ready);

    // Grant/transaction FSM; a reset drops any in-flight beat back to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IFU;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                    if (lsu_win_s) begin
                        owner_q <= OWN_LSU;
                        state_q <= lsu_wr_s ? ST_WR : ST_RD;
                    end else if (ifu_req.ar_valid) begin
                        owner_q <= OWN_IFU;
                        state_q <= ST_RD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD: begin
                    state_q <= r_hs_s ? ST_IDLE : ST_RD;
                end
                ST_WR: begin
                    aw_done_q <= aw_done_d;
                    w_done_q  <= w_done_d;
                    state_q   <= (aw_done_d && w_done_d) ? ST_WR_RESP : ST_WR;
                end
                ST_WR_RESP: begin
                    state_q <= b_hs_s ? ST_IDLE : ST_WR_RESP;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Channel mux: owner's channels go to memory, memory's reply goes only to the owner.
    always_comb begin
        mem_req   = '0;
        own_rsp_s = '0;
        ifu_rsp   = '0;
        lsu_rsp   = '0;
        sel_req_s = (owner_q == OWN_LSU) ? lsu_req : ifu_req;
        case (state_q)
            ST_RD: begin
                mem_req.ar_valid   = sel_req_s.ar_valid;
                mem_req.araddr     = sel_req_s.araddr;
                mem_req.r_ready    = sel_req_s.r_ready;
                own_rsp_s.ar_ready = mem_rsp.ar_ready;
                own_rsp_s.r_valid  = mem_rsp.r_valid;
                own_rsp_s.rdata    = mem_rsp.rdata;
                own_rsp_s.rresp    = mem_rsp.rresp;
            end
            ST_WR: begin
                // A channel that already handshook is masked so memory sees each beat once.
                mem_req.aw_valid   = lsu_req.aw_valid & ~aw_done_q;
                mem_req.awaddr     = lsu_req.awaddr;
                mem_req.w_valid    = lsu_req.w_valid & ~w_done_q;
                mem_req.wdata      = lsu_req.wdata;
                mem_req.wstrb      = lsu_req.wstrb;
                own_rsp_s.aw_ready = mem_rsp.aw_ready & ~aw_done_q;
                own_rsp_s.w_ready  = mem_rsp.w_ready & ~w_done_q;
            end
            ST_WR_RESP: begin
                mem_req.b_ready   = lsu_req.b_ready;
                own_rsp_s.b_valid = mem_rsp.b_valid;
                own_rsp_s.bresp   = mem_rsp.bresp;
            end
            default: begin
                own_rsp_s = '0;
            end
        endcase
        if (owner_q == OWN_LSU) begin
            lsu_rsp = own_rsp_s;
        end else begin
            ifu_rsp = own_rsp_s;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one instance per priority setting,
// driven in lockstep where the priority scenario is compared.
module tb_mem_arbiter;
    import axil_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    axil_req_t ifu_req, lsu_req, mem_req;
    axil_rsp_t ifu_rsp, lsu_rsp, mem_rsp;
    axil_req_t ifu_req0, lsu_req0, mem_req0;
    axil_rsp_t ifu_rsp0, lsu_rsp0, mem_rsp0;
    int        n_assert = 0;
    int        n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LSU_PRIORITY(1'b1)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_rsp(ifu_rsp),
        .lsu_req(lsu_req), .lsu_rsp(lsu_rsp),
        .mem_req(mem_req), .mem_rsp(mem_rsp)
    );

    mem_arbiter #(.LSU_PRIORITY(1'b0)) dut0 (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req0), .ifu_rsp(ifu_rsp0),
        .lsu_req(lsu_req0), .lsu_rsp(lsu_rsp0),
        .mem_req(mem_req0), .mem_rsp(mem_rsp0)
    );

    mem_arbiter_chk u_chk (.clk(clk), .rst(rst), .ifu_req(ifu_req));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        ifu_req  = '0; lsu_req  = '0; mem_rsp  = '0;
        ifu_req0 = '0; lsu_req0 = '0; mem_rsp0 = '0;
    endtask

    initial begin
        clear_all();
        rst = 1'b1;
        cyc(); cyc();
        #1;
        chk("rst_mem_ar_valid", {63'd0, mem_req.ar_valid}, 64'd0);
        chk("rst_lsu_b_valid",  {63'd0, lsu_rsp.b_valid},  64'd0);
        rst = 1'b0;
        cyc();

        // 1: IFU read, data three cycles after AR
        ifu_req.ar_valid = 1'b1; ifu_req.araddr = 32'h8000_0000; ifu_req.r_ready = 1'b1;
        #1;
        chk("t1_idle_no_ar", {63'd0, mem_req.ar_valid}, 64'd0);
        cyc();
        mem_rsp.ar_ready = 1'b1;
        #1;
        chk("t1_mem_araddr", {32'd0, mem_req.araddr}, 64'h8000_0000);
        chk("t1_ifu_ar_ready", {63'd0, ifu_rsp.ar_ready}, 64'd1);
        cyc();
        ifu_req.ar_valid = 1'b0; mem_rsp.ar_ready = 1'b0;
        cyc(); cyc();
        mem_rsp.r_valid = 1'b1; mem_rsp.rdata = 32'h0000_0413; mem_rsp.rresp = RESP_OKAY;
        #1;
        chk("t1_ifu_r_valid", {63'd0, ifu_rsp.r_valid}, 64'd1);
        chk("t1_ifu_rdata", {32'd0, ifu_rsp.rdata}, 64'h0000_0413);
        chk("t1_ifu_rresp", {62'd0, ifu_rsp.rresp}, 64'd0);
        chk("t1_lsu_rsp_zero", {22'd0, lsu_rsp}, 64'd0);
        cyc();
        mem_rsp.r_valid = 1'b0;
        ifu_req.ar_valid = 1'b1;
        #1;
        chk("t1_back_idle", {63'd0, mem_req.ar_valid}, 64'd0);
        clear_all();
        cyc();

        // 2: simultaneous reads, both priority settings in lockstep
        ifu_req.ar_valid  = 1'b1; ifu_req.araddr  = 32'h2000; ifu_req.r_ready  = 1'b1;
        lsu_req.ar_valid  = 1'b1; lsu_req.araddr  = 32'h1000; lsu_req.r_ready  = 1'b1;
        ifu_req0 = ifu_req; lsu_req0 = lsu_req;
        cyc();
        mem_rsp.ar_ready = 1'b1; mem_rsp0.ar_ready = 1'b1;
        #1;
        chk("t2p1_first_addr", {32'd0, mem_req.araddr}, 64'h1000);
        chk("t2p1_lsu_ar_ready", {63'd0, lsu_rsp.ar_ready}, 64'd1);
        chk("t2p1_ifu_ar_ready", {63'd0, ifu_rsp.ar_ready}, 64'd0);
        chk("t2p0_first_addr", {32'd0, mem_req0.araddr}, 64'h2000);
        chk("t2p0_lsu_ar_ready", {63'd0, lsu_rsp0.ar_ready}, 64'd0);
        cyc();
        lsu_req.ar_valid = 1'b0; ifu_req0.ar_valid = 1'b0;
        mem_rsp.ar_ready = 1'b0; mem_rsp0.ar_ready = 1'b0;
        mem_rsp.r_valid = 1'b1; mem_rsp.rdata = 32'h11;
        mem_rsp0.r_valid = 1'b1; mem_rsp0.rdata = 32'h11;
        #1;
        chk("t2p1_lsu_r_valid", {63'd0, lsu_rsp.r_valid}, 64'd1);
        chk("t2p1_ifu_r_valid", {63'd0, ifu_rsp.r_valid}, 64'd0);
        chk("t2p0_ifu_r_valid", {63'd0, ifu_rsp0.r_valid}, 64'd1);
        chk("t2p0_lsu_r_valid", {63'd0, lsu_rsp0.r_valid}, 64'd0);
        cyc();
        mem_rsp.r_valid = 1'b0; mem_rsp0.r_valid = 1'b0;
        #1;
        chk("t2p1_idle_gap", {63'd0, mem_req.ar_valid}, 64'd0);
        chk("t2p0_idle_gap", {63'd0, mem_req0.ar_valid}, 64'd0);
        cyc();
        chk("t2p1_second_addr", {32'd0, mem_req.araddr}, 64'h2000);
        chk("t2p1_second_valid", {63'd0, mem_req.ar_valid}, 64'd1);
        chk("t2p0_second_addr", {32'd0, mem_req0.araddr}, 64'h1000);
        mem_rsp.ar_ready = 1'b1; mem_rsp0.ar_ready = 1'b1;
        cyc();
        ifu_req.ar_valid = 1'b0; lsu_req0.ar_valid = 1'b0;
        mem_rsp.ar_ready = 1'b0; mem_rsp0.ar_ready = 1'b0;
        mem_rsp.r_valid = 1'b1; mem_rsp0.r_valid = 1'b1;
        cyc();
        clear_all();
        cyc();

        // 3: LSU write, W two cycles ahead of AW; W valid held to exercise masking
        lsu_req.w_valid = 1'b1; lsu_req.wdata = 32'hDEAD_BEEF; lsu_req.wstrb = 4'b0011;
        lsu_req.b_ready = 1'b1;
        cyc();
        mem_rsp.w_ready = 1'b1;
        #1;
        chk("t3_mem_w_valid", {63'd0, mem_req.w_valid}, 64'd1);
        chk("t3_mem_wdata", {32'd0, mem_req.wdata}, 64'hDEAD_BEEF);
        chk("t3_mem_wstrb", {60'd0, mem_req.wstrb}, 64'h3);
        chk("t3_aw_not_yet", {63'd0, mem_req.aw_valid}, 64'd0);
        chk("t3_lsu_w_ready", {63'd0, lsu_rsp.w_ready}, 64'd1);
        cyc();
        chk("t3_w_masked", {63'd0, mem_req.w_valid}, 64'd0);
        chk("t3_w_ready_masked", {63'd0, lsu_rsp.w_ready}, 64'd0);
        cyc();
        lsu_req.aw_valid = 1'b1; lsu_req.awaddr = 32'h8000_0100; mem_rsp.aw_ready = 1'b1;
        #1;
        chk("t3_mem_aw_valid", {63'd0, mem_req.aw_valid}, 64'd1);
        chk("t3_mem_awaddr", {32'd0, mem_req.awaddr}, 64'h8000_0100);
        chk("t3_w_still_masked", {63'd0, mem_req.w_valid}, 64'd0);
        cyc();
        lsu_req.aw_valid = 1'b0; lsu_req.w_valid = 1'b0;
        mem_rsp.aw_ready = 1'b0; mem_rsp.w_ready = 1'b0;
        mem_rsp.b_valid = 1'b1; mem_rsp.bresp = RESP_OKAY;
        #1;
        chk("t3_lsu_b_valid", {63'd0, lsu_rsp.b_valid}, 64'd1);
        chk("t3_mem_b_ready", {63'd0, mem_req.b_ready}, 64'd1);
        cyc();
        mem_rsp.b_valid = 1'b0;
        lsu_req.ar_valid = 1'b1;
        #1;
        chk("t3_back_idle", {63'd0, mem_req.ar_valid}, 64'd0);
        clear_all();
        cyc();

        // 4: LSU read with r_ready held low for four cycles
        lsu_req.ar_valid = 1'b1; lsu_req.araddr = 32'h3000;
        cyc();
        mem_rsp.ar_ready = 1'b1;
        cyc();
        lsu_req.ar_valid = 1'b0; mem_rsp.ar_ready = 1'b0;
        mem_rsp.r_valid = 1'b1; mem_rsp.rdata = 32'h44;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_bp_r_ready", {63'd0, mem_req.r_ready}, 64'd0);
            chk("t4_bp_r_valid", {63'd0, lsu_rsp.r_valid}, 64'd1);
            cyc();
        end
        lsu_req.r_ready = 1'b1;
        #1;
        chk("t4_fifth_r_ready", {63'd0, mem_req.r_ready}, 64'd1);
        chk("t4_fifth_rdata", {32'd0, lsu_rsp.rdata}, 64'h44);
        cyc();
        mem_rsp.r_valid = 1'b0;
        #1;
        chk("t4_back_idle", {63'd0, mem_req.r_ready}, 64'd0);
        clear_all();
        cyc();

        // 5: reset while a read response is pending
        ifu_req.ar_valid = 1'b1; ifu_req.araddr = 32'h4000;
        cyc();
        mem_rsp.ar_ready = 1'b1;
        cyc();
        ifu_req.ar_valid = 1'b0; mem_rsp.ar_ready = 1'b0;
        mem_rsp.r_valid = 1'b1; mem_rsp.rdata = 32'hBAD;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        ifu_req.r_ready = 1'b1;
        #1;
        chk("t5_ifu_r_valid", {63'd0, ifu_rsp.r_valid}, 64'd0);
        chk("t5_mem_r_ready", {63'd0, mem_req.r_ready}, 64'd0);
        mem_rsp.r_valid = 1'b0;
        ifu_req.ar_valid = 1'b1; ifu_req.araddr = 32'h5000;
        cyc();
        mem_rsp.ar_ready = 1'b1;
        #1;
        chk("t5_fresh_araddr", {32'd0, mem_req.araddr}, 64'h5000);
        cyc();
        ifu_req.ar_valid = 1'b0; mem_rsp.ar_ready = 1'b0;
        mem_rsp.r_valid = 1'b1; mem_rsp.rdata = 32'h55;
        #1;
        chk("t5_fresh_rdata", {32'd0, ifu_rsp.rdata}, 64'h55);
        chk("t5_fresh_r_valid", {63'd0, ifu_rsp.r_valid}, 64'd1);
        cyc();
        clear_all();
        cyc();

        // 6: error responses pass through untouched
        lsu_req.ar_valid = 1'b1; lsu_req.araddr = 32'h6000; lsu_req.r_ready = 1'b1;
        cyc();
        mem_rsp.ar_ready = 1'b1;
        cyc();
        lsu_req.ar_valid = 1'b0; mem_rsp.ar_ready = 1'b0;
        mem_rsp.r_valid = 1'b1; mem_rsp.rresp = RESP_SLVERR; mem_rsp.rdata = 32'h66;
        #1;
        chk("t6_rresp_slverr", {62'd0, lsu_rsp.rresp}, 64'h2);
        cyc();
        clear_all();
        cyc();
        lsu_req.aw_valid = 1'b1; lsu_req.awaddr = 32'h7000;
        lsu_req.w_valid = 1'b1; lsu_req.wdata = 32'h77; lsu_req.wstrb = 4'hF;
        lsu_req.b_ready = 1'b1;
        cyc();
        mem_rsp.aw_ready = 1'b1; mem_rsp.w_ready = 1'b1;
        #1;
        chk("t6_both_valid", {62'd0, mem_req.aw_valid, mem_req.w_valid}, 64'h3);
        cyc();
        lsu_req.aw_valid = 1'b0; lsu_req.w_valid = 1'b0;
        mem_rsp.aw_ready = 1'b0; mem_rsp.w_ready = 1'b0;
        mem_rsp.b_valid = 1'b1; mem_rsp.bresp = RESP_DECERR;
        #1;
        chk("t6_b_valid", {63'd0, lsu_rsp.b_valid}, 64'd1);
        chk("t6_bresp_decerr", {62'd0, lsu_rsp.bresp}, 64'h3);
        cyc();
        clear_all();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
